// File: rtl/noise_share_ctrl.sv
// Sequences one noise generator through a warm-up discard phase, then hands each
// valid sample to exactly one requesting channel in round-robin order.
module noise_share_ctrl #(
  parameter int NUM_CH         = 4,
  parameter int WARMUP_SAMPLES = 4,
  parameter int DROP_W         = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [NUM_CH-1:0] req,
  input  logic [7:0]        noise_in,
  input  logic              noise_in_valid,
  output logic              noise_en,
  output logic [7:0]        noise_out,
  output logic [NUM_CH-1:0] noise_out_valid,
  output logic              ready,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WCNT_W = (WARMUP_SAMPLES > 1) ? $clog2(WARMUP_SAMPLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t            state_r;
  logic [WCNT_W-1:0] warm_cnt_r;
  logic [PTR_W-1:0]  ptr_r;
  logic              noise_en_r;
  logic [7:0]        noise_out_r;
  logic [NUM_CH-1:0] out_valid_r;
  logic              ready_r;
  logic [DROP_W-1:0] drop_cnt_r;

  logic              grant_found_s;
  logic [PTR_W-1:0]  grant_idx_s;
  logic [PTR_W-1:0]  ptr_next_s;

  // Round-robin search: scan downward so the last hit is the one nearest the pointer.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      logic [PTR_W-1:0] idx_v;
      idx_v = PTR_W'((int'(ptr_r) + k) % NUM_CH);
      if (req[idx_v]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = idx_v;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
    if (grant_idx_s == PTR_W'(NUM_CH - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_idx_s + PTR_W'(1);
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      warm_cnt_r  <= '0;
      ptr_r       <= '0;
      noise_en_r  <= 1'b0;
      noise_out_r <= 8'd0;
      out_valid_r <= '0;
      ready_r     <= 1'b0;
      drop_cnt_r  <= '0;
    end else begin
      out_valid_r <= '0;
      if (!en) begin
        // Disable wins in every state; drop_cnt is deliberately kept.
        state_r    <= IDLE;
        warm_cnt_r <= '0;
        ptr_r      <= '0;
        noise_en_r <= 1'b0;
        ready_r    <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            noise_en_r <= 1'b1;
            if (WARMUP_SAMPLES == 0) begin
              state_r <= RUN;
              ready_r <= 1'b1;
            end else begin
              state_r <= WARMUP;
            end
          end
          WARMUP: begin
            if (noise_in_valid) begin
              if (warm_cnt_r == WCNT_W'(WARMUP_SAMPLES - 1)) begin
                state_r    <= RUN;
                ready_r    <= 1'b1;
                warm_cnt_r <= '0;
              end else begin
                warm_cnt_r <= warm_cnt_r + WCNT_W'(1);
              end
            end
          end
          RUN: begin
            if (noise_in_valid) begin
              if (grant_found_s) begin
                noise_out_r <= noise_in;
                out_valid_r <= {{(NUM_CH-1){1'b0}}, 1'b1} << grant_idx_s;
                ptr_r       <= ptr_next_s;
              end else if (drop_cnt_r != {DROP_W{1'b1}}) begin
                drop_cnt_r <= drop_cnt_r + DROP_W'(1);
              end
            end
          end
          default: begin
            state_r    <= IDLE;
            noise_en_r <= 1'b0;
            ready_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign noise_en        = noise_en_r;
  assign noise_out       = noise_out_r;
  assign noise_out_valid = out_valid_r;
  assign ready           = ready_r;
  assign drop_cnt        = drop_cnt_r;

endmodule

// File: tb/tb_noise_share_ctrl.sv
// Directed bench for noise_share_ctrl: a behavioural model is compared every cycle,
// and literal expectations pin key points of the sequence.
module tb_noise_share_ctrl;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          en = 1'b0;
  logic [N-1:0]  req = '0;
  logic [7:0]    noise_in = 8'd0;
  logic          noise_in_valid = 1'b0;
  logic          noise_en;
  logic [7:0]    noise_out;
  logic [N-1:0]  noise_out_valid;
  logic          ready;
  logic [DW-1:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  noise_share_ctrl #(.NUM_CH(N), .WARMUP_SAMPLES(W), .DROP_W(DW)) dut (
    .clk(clk), .rstn(rstn), .en(en), .req(req), .noise_in(noise_in),
    .noise_in_valid(noise_in_valid), .noise_en(noise_en), .noise_out(noise_out),
    .noise_out_valid(noise_out_valid), .ready(ready), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Model state: phase 0=off, 1=discarding, 2=sharing.
  int           m_phase, m_seen, m_ptr, m_drop;
  logic         e_en, e_rdy;
  logic [7:0]   e_out;
  logic [N-1:0] e_vld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural reference: outputs after each edge follow directly from the rules.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_phase <= 0; m_seen <= 0; m_ptr <= 0; m_drop <= 0;
      e_en <= 1'b0; e_rdy <= 1'b0; e_out <= 8'd0; e_vld <= '0;
    end else begin
      int ph, sn, pt, dr, hit;
      ph = m_phase; sn = m_seen; pt = m_ptr; dr = m_drop;
      e_vld <= '0;
      if (!en) begin
        ph = 0; sn = 0; pt = 0;
      end else if (ph == 0) begin
        ph = (W > 0) ? 1 : 2;
      end else if (ph == 1) begin
        if (noise_in_valid) begin
          sn = sn + 1;
          if (sn == W) begin ph = 2; sn = 0; end
        end
      end else if (noise_in_valid) begin
        hit = -1;
        for (int k = 0; k < N; k++)
          if (hit < 0 && req[(pt + k) % N]) hit = (pt + k) % N;
        if (hit >= 0) begin
          e_out <= noise_in;
          e_vld <= N'(1) << hit;
          pt = (hit + 1) % N;
        end else if (dr < (1 << DW) - 1) begin
          dr = dr + 1;
        end
      end
      m_phase <= ph; m_seen <= sn; m_ptr <= pt; m_drop <= dr;
      e_en  <= (ph != 0);
      e_rdy <= (ph == 2);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      chk("noise_en", 32'(noise_en), 32'(e_en));
      chk("ready", 32'(ready), 32'(e_rdy));
      chk("noise_out_valid", 32'(noise_out_valid), 32'(e_vld));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (e_vld != '0) chk("noise_out", 32'(noise_out), 32'(e_out));
    end
  end

  task automatic step(input logic e, input logic [N-1:0] r, input logic v, input logic [7:0] d);
    @(negedge clk);
    en = e; req = r; noise_in_valid = v; noise_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [N-1:0] vld, input logic [7:0] out);
    chk({name, "_vld"}, 32'(noise_out_valid), 32'(vld));
    chk({name, "_out"}, 32'(noise_out), 32'(out));
  endtask

  initial begin
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    chk("rst_en", 32'(noise_en), 32'd0);
    chk("rst_rdy", 32'(ready), 32'd0);
    lit("rst", 4'b0000, 8'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    // Enable and warm-up: samples 1..4 discarded.
    step(1'b1, 4'b0001, 1'b0, 8'd0);
    chk("en_rise", 32'(noise_en), 32'd1);
    chk("warm_rdy0", 32'(ready), 32'd0);
    for (int s = 1; s <= 4; s++) begin
      step(1'b1, 4'b0001, 1'b1, 8'(s));
      chk("warm_rdy", 32'(ready), (s == 4) ? 32'd1 : 32'd0);
      chk("warm_vld", 32'(noise_out_valid), 32'd0);
    end
    step(1'b1, 4'b0001, 1'b1, 8'd5);
    lit("first", 4'b0001, 8'd5);

    // Park pointer at 0 via ch3, then full round-robin.
    step(1'b1, 4'b1000, 1'b1, 8'd6);
    lit("park", 4'b1000, 8'd6);
    for (int s = 10; s <= 14; s++) begin
      step(1'b1, 4'b1111, 1'b1, 8'(s));
      lit("rr", N'(1) << ((s - 10) % N), 8'(s));
    end

    // Drops with no requester; pointer stays at 1.
    for (int s = 20; s <= 22; s++) begin
      step(1'b1, 4'b0000, 1'b1, 8'(s));
      chk("drop_vld", 32'(noise_out_valid), 32'd0);
    end
    chk("drop_cnt3", 32'(drop_cnt), 32'd3);
    step(1'b1, 4'b1111, 1'b1, 8'd23);
    lit("after_drop", 4'b0010, 8'd23);
    step(1'b1, 4'b1000, 1'b1, 8'd24);

    // Sparse requesters then a gap in valid.
    for (int s = 30; s <= 33; s++) begin
      step(1'b1, 4'b0101, 1'b1, 8'(s));
      lit("sparse", ((s % 2) == 0) ? 4'b0001 : 4'b0100, 8'(s));
    end
    for (int g = 0; g < 2; g++) begin
      step(1'b1, 4'b1111, 1'b0, 8'hAA);
      lit("gap", 4'b0000, 8'd33);
    end

    // Disable mid-run with a sample present.
    step(1'b0, 4'b1111, 1'b1, 8'd40);
    chk("dis_en", 32'(noise_en), 32'd0);
    chk("dis_rdy", 32'(ready), 32'd0);
    lit("dis", 4'b0000, 8'd33);
    chk("dis_drop", 32'(drop_cnt), 32'd3);
    step(1'b0, 4'b1111, 1'b1, 8'd41);

    // Re-enable repeats warm-up; pointer restarts at 0.
    step(1'b1, 4'b0110, 1'b0, 8'd0);
    for (int s = 50; s <= 53; s++) begin
      step(1'b1, 4'b0110, 1'b1, 8'(s));
      chk("rewarm_vld", 32'(noise_out_valid), 32'd0);
      chk("rewarm_rdy", 32'(ready), (s == 53) ? 32'd1 : 32'd0);
    end
    step(1'b1, 4'b0110, 1'b1, 8'd54);
    lit("reen", 4'b0010, 8'd54);
    step(1'b1, 4'b1010, 1'b1, 8'd55);

    // Asynchronous reset between edges.
    #2 rstn = 1'b0;
    #1;
    chk("arst_en", 32'(noise_en), 32'd0);
    chk("arst_rdy", 32'(ready), 32'd0);
    lit("arst", 4'b0000, 8'd0);
    chk("arst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk) rstn = 1'b1;
    step(1'b0, 4'b1111, 1'b1, 8'd60);
    chk("idle_en", 32'(noise_en), 32'd0);
    chk("idle_vld", 32'(noise_out_valid), 32'd0);
    step(1'b0, 4'b0000, 1'b0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noise_share_ctrl.md
Name: noise_share_ctrl

Overview:
Controller that sequences a single noise generator (8-bit noise stream with valid strobe) and shares its samples among NUM_CH receiver channels. It enables the generator and discards a fixed number of warm-up samples so the generator can settle. It then hands each valid sample to exactly one requesting channel, chosen by round-robin. It sits between the noise source and the per-channel noise-injection points of the Rx simulation path.

Parameters:
NUM_CH, 4, number of requesting channels (>=2)
WARMUP_SAMPLES, 4, valid samples discarded after each enable before forwarding (0 = no warm-up)
DROP_W, 16, width of dropped-sample counter

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
en  input  1  global enable for noise sharing
req  input  NUM_CH  per-channel noise request, level-sensitive
noise_in  input  8  sample from noise generator
noise_in_valid  input  1  noise_in qualifier
noise_en  output  1  enable to noise generator
noise_out  output  8  forwarded sample, common to all channels
noise_out_valid  output  NUM_CH  one-hot grant/valid; bit i = sample is for channel i
ready  output  1  warm-up complete, forwarding active
drop_cnt  output  DROP_W  valid samples arriving in RUN with no requester, saturating

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; noise_en, noise_out, noise_out_valid, ready and drop_cnt all 0; warm-up counter 0; round-robin pointer 0.
- All outputs are registered.
- FSM states: IDLE, WARMUP, RUN.
- IDLE -> WARMUP when en=1 and WARMUP_SAMPLES>0.
- IDLE -> RUN when en=1 and WARMUP_SAMPLES=0.
- WARMUP: noise_en=1 (registered, so it rises the cycle after the transition out of IDLE). Each noise_in_valid increments the warm-up counter; the sample is discarded.
- WARMUP -> RUN on the clock edge that accepts the WARMUP_SAMPLES-th valid sample. That sample is discarded. ready=1 from the following cycle.
- RUN: noise_en=1, ready=1. On a cycle with noise_in_valid=1:
  - If req!=0: grant the first set req bit found searching upward from the pointer, wrapping modulo NUM_CH.
  - Next cycle: noise_out=noise_in and noise_out_valid=one-hot of the granted channel. Latency 1 cycle.
  - Pointer becomes granted index + 1, mod NUM_CH.
- If noise_in_valid=1 and req=0 in RUN: the sample is dropped, drop_cnt increments (saturates at all-ones), pointer unchanged, noise_out_valid=0.
- When noise_in_valid=0: noise_out_valid=0 next cycle; noise_out holds its last value.
- noise_in_valid is ignored in IDLE.
- Any state with en=0 -> IDLE on the next edge:
  - noise_en, ready and noise_out_valid go 0 that edge.
  - A sample valid in that same cycle is not forwarded.
  - Warm-up counter and pointer are cleared; drop_cnt is preserved.
- Re-enabling always repeats the full warm-up.
- req may change every cycle; only the value sampled in the cycle of noise_in_valid matters.
- Exactly one noise_out_valid bit is ever set.

Test Plan:
- NUM_CH=4, WARMUP_SAMPLES=4. Reset, en=1, noise_in_valid=1 every cycle carrying 1,2,3,...; req=4'b0001 -> noise_en=1 one cycle after en; samples 1-4 discarded; ready=1 the cycle after sample 4 is accepted; first output noise_out=5 with noise_out_valid=4'b0001 one cycle after sample 5.
- In RUN, req=4'b1111, samples 10..14 -> grants ch0,ch1,ch2,ch3,ch0 in order, each noise_out equal to its sample, 1-cycle latency.
- In RUN, req=4'b0000 for 3 valid samples -> noise_out_valid stays 0, drop_cnt=3, pointer unchanged; next req=4'b1111 grants the channel the pointer was at.
- req=4'b0101, 4 consecutive samples -> grants ch0,ch2,ch0,ch2. Then noise_in_valid gap of 2 cycles -> noise_out_valid=0 and noise_out held.
- en=0 mid-RUN with a sample valid in that cycle -> next edge noise_en=0, ready=0, noise_out_valid=0, sample not forwarded, drop_cnt unchanged. Re-assert en -> 4 samples discarded again; first grant goes to lowest requesting channel (pointer 0).
- Assert rstn=0 mid-RUN between clock edges -> all outputs including drop_cnt go 0 immediately without a clock edge. Release -> FSM in IDLE.
